// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the text-VRAM port arbiter.
// Optional build macro VRAM_ARB_STATS_EN enables the CPU stall counter.
package vram_arb_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;  // 80x60 text map fits in 8K words
    localparam int unsigned VRAM_DATA_W = 16;  // attribute byte + character code
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StVgaAcc,
        StVgaCap,
        StCpuAcc,
        StCpuCap
    } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for arbiter statistics.
// Only built when VRAM_ARB_STATS_EN is defined.
`ifdef VRAM_ARB_STATS_EN
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/vram_port_arbiter.sv
// Single-port text-VRAM arbiter: the VGA fetch path has fixed priority and a
// bounded latency, the CPU bus is served through a req/ready handshake.
// Optional build macro VRAM_ARB_STATS_EN adds the stall_cnt output.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_rdn,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic              served_q, served_d;
    logic              vga_pend;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // A low strobe that has not yet been fetched.
    assign vga_pend = !vga_rdn && !served_q;

    // Next-state and served-flag logic. Capture cycles double as arbitration
    // slots so a pending VGA fetch follows a CPU access with no idle gap. The
    // CPU is never re-granted straight out of CPU_CAP: cpu_req is still high
    // at that edge for the access that is just completing.
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        unique case (state_q)
            StIdle, StVgaCap: begin
                if (vga_pend) begin
                    state_d = StVgaAcc;
                end else if (cpu_req) begin
                    state_d = StCpuAcc;
                end else begin
                    state_d = StIdle;
                end
            end
            StVgaAcc: state_d = StVgaCap;
            StCpuAcc: state_d = StCpuCap;
            StCpuCap: state_d = vga_pend ? StVgaAcc : StIdle;
            default:  state_d = StIdle;
        endcase
        if (state_d == StVgaAcc && state_q != StVgaAcc) begin
            served_d = 1'b1;
        end
        if (vga_rdn) begin
            served_d = 1'b0;
        end
    end

    // RAM port and CPU handshake outputs; address/data hold when the port idles.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        unique case (state_q)
            StVgaAcc: begin
                ram_en   = 1'b1;
                ram_addr = vga_addr;
            end
            StCpuAcc: begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            default: ;
        endcase
        // Reset aborts the access in flight: nothing reaches the RAM or the CPU.
        if (rst) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    // Read data is forwarded during the ready cycle and held afterwards.
    always_comb begin
        cpu_ready = (state_q == StCpuCap) && !rst;
        cpu_rdata = cpu_rdata_q;
        if (cpu_ready && !we_q) begin
            cpu_rdata = ram_rdata;
        end
    end

    assign vga_data = vga_data_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
        end
    end

    // Datapath registers: held port values, access direction, captured data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
            if (state_q == StCpuAcc) begin
                we_q <= cpu_we;
            end
            if (state_q == StVgaCap) begin
                vga_data_q <= ram_rdata;
            end
            if (state_q == StCpuCap && !we_q) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic stall_inc;

    // CPU is waiting while the port is granted to, or busy with, a VGA fetch.
    always_comb begin
        stall_inc = cpu_req && (((state_q == StIdle) && vga_pend) ||
                                (state_q == StVgaAcc) || (state_q == StVgaCap));
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter with a behavioural VRAM, a shadow
// memory and expected-value queues for the CPU and VGA paths.
`timescale 1ns/1ps
module tb_vram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_rdn;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] vga_exp_q[$];

    vram_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .vga_rdn  (vga_rdn),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous single-port VRAM, plus a count of read-enable cycles.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
        if (!rst && ram_en && !ram_we) rd_cnt <= rd_cnt + 1;
    end

`ifdef VRAM_ARB_STATS_EN
    // Stall cycles seen from the pins: VGA fetches use addresses >= 0x1000
    // while CPU traffic in the random phase stays below.
    int stall_model = 0;
    bit stat_en = 1'b0;
    bit prev_vacc = 1'b0, prev_req = 1'b0, prev_rdy = 1'b0;
    always @(posedge clk) begin
        automatic bit cur_vacc = ram_en && !ram_we && ram_addr[AW-1];
        automatic int inc = 0;
        if (stat_en) begin
            if (cur_vacc && cpu_req) inc++;
            if (prev_vacc && cpu_req) inc++;
            if (cur_vacc && prev_req && !prev_rdy) inc++;
        end
        stall_model <= stall_model + inc;
        prev_vacc <= cur_vacc;
        prev_req  <= cpu_req;
        prev_rdy  <= cpu_ready;
    end
`endif

    function automatic logic [DW-1:0] pattern(input int a);
        logic [31:0] t;
        t = a * 32'd40503;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access; returns cycles to ready and number of ram_we cycles seen.
    task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, output int lat, output int we_cyc);
        logic [DW-1:0] exp;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        if (we) ref_mem[addr] = wd;
        else    cpu_exp_q.push_back(ref_mem[addr]);
        lat    = 0;
        we_cyc = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (ram_we === 1'b1) we_cyc++;
            if (cpu_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL cpu_ready_timeout addr=%h waited=16", addr);
            if (!we) void'(cpu_exp_q.pop_front());
        end else if (!we) begin
            exp = cpu_exp_q.pop_front();
            checks++;
            if (cpu_rdata !== exp) begin
                failures++;
                $display("FAIL cpu_rdata addr=%h got=%h exp=%h", addr, cpu_rdata, exp);
            end
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] exp;
        int got = 0;
        rst = 1'b1; vga_rdn = 1'b0; vga_addr = 13'h0124;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200; cpu_wdata = 16'hFFFF;
        cpu_exp_q.push_back(ref_mem[13'h0200]);
        vga_exp_q.push_back(ref_mem[13'h0124]);
        repeat (3) tick();
        checks++; if (vga_data !== '0)  begin failures++; $display("FAIL rst_vga_data got=%h exp=0", vga_data); end
        checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL rst_cpu_rdata got=%h exp=0", cpu_rdata); end
        checks++; if (cpu_ready !== 0)  begin failures++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu_ready); end
        checks++; if (ram_en !== 0)     begin failures++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
        checks++; if (ram_we !== 0)     begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
        checks++; if (ram_addr !== '0)  begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
        checks++; if (ram_wdata !== '0) begin failures++; $display("FAIL rst_ram_wdata got=%h exp=0", ram_wdata); end
`ifdef VRAM_ARB_STATS_EN
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall_cnt got=%h exp=0", stall_cnt); end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 13'h0124) begin
            failures++;
            $display("FAIL first_grant en=%b we=%b addr=%h exp en=1 we=0 addr=0124",
                     ram_en, ram_we, ram_addr);
        end
        tick();
        tick();
        exp = vga_exp_q.pop_front();
        checks++;
        if (vga_data !== exp) begin
            failures++; $display("FAIL rst_vga_fetch got=%h exp=%h", vga_data, exp);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (cpu_ready === 1'b1) begin got = i; break; end
        end
        exp = cpu_exp_q.pop_front();
        checks++;
        if (got == 0 || cpu_rdata !== exp) begin
            failures++; $display("FAIL rst_cpu_after_vga ready_at=%0d got=%h exp=%h", got, cpu_rdata, exp);
        end
        tick();
        cpu_req = 1'b0; vga_rdn = 1'b1;
        tick();
    endtask

    task automatic test_vga_alone();
        int base;
        logic [DW-1:0] exp;
        vga_rdn = 1'b1;
        repeat (2) tick();
        base = rd_cnt;
        vga_addr = 13'h0123;
        vga_rdn = 1'b0;
        vga_exp_q.push_back(ref_mem[13'h0123]);
        repeat (3) tick();
        exp = vga_exp_q.pop_front();
        checks++;
        if (vga_data !== exp) begin failures++; $display("FAIL vga_alone_data got=%h exp=%h", vga_data, exp); end
        repeat (5) tick();  // strobe held low well past the fetch
        checks++;
        if (rd_cnt - base !== 1) begin failures++; $display("FAIL vga_single_fetch got=%0d exp=1", rd_cnt - base); end
        vga_rdn = 1'b1;
        tick();
        vga_rdn = 1'b0;
        repeat (4) tick();
        vga_rdn = 1'b1;
        tick();
        checks++;
        if (rd_cnt - base !== 2) begin failures++; $display("FAIL vga_refetch got=%0d exp=2", rd_cnt - base); end
    endtask

    task automatic test_cpu_write_read();
        int lat, wc;
        cpu_access(1'b1, 13'h0050, 16'hABCD, lat, wc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (wc !== 1)  begin failures++; $display("FAIL wr_we_cycles got=%0d exp=1", wc); end
        cpu_access(1'b0, 13'h0050, 16'h0000, lat, wc);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        cpu_access(1'b1, 13'h0051, 16'h1234, lat, wc);
        checks++;
        if (cpu_rdata !== 16'hABCD) begin
            failures++; $display("FAIL rdata_hold_on_write got=%h exp=abcd", cpu_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int lat = 0;
        logic [DW-1:0] exp;
`ifdef VRAM_ARB_STATS_EN
        logic [15:0] st0;
`endif
        vga_rdn = 1'b1;
        tick();
`ifdef VRAM_ARB_STATS_EN
        st0 = stall_cnt;
`endif
        vga_addr = 13'h0300; vga_rdn = 1'b0;
        vga_exp_q.push_back(ref_mem[13'h0300]);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0050;
        cpu_exp_q.push_back(ref_mem[13'h0050]);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) begin
                exp = vga_exp_q.pop_front();
                checks++;
                if (vga_data !== exp) begin failures++; $display("FAIL sim_vga_data got=%h exp=%h", vga_data, exp); end
            end
            if (cpu_ready === 1'b1) begin lat = i; break; end
        end
        exp = cpu_exp_q.pop_front();
        checks++; if (lat !== 4) begin failures++; $display("FAIL sim_cpu_latency got=%0d exp=4", lat); end
        checks++; if (cpu_rdata !== exp) begin failures++; $display("FAIL sim_cpu_rdata got=%h exp=%h", cpu_rdata, exp); end
`ifdef VRAM_ARB_STATS_EN
        checks++;
        if (stall_cnt - st0 !== 16'd3) begin
            failures++; $display("FAIL sim_stall_cnt got=%0d exp=3", stall_cnt - st0);
        end
`endif
        tick();
        cpu_req = 1'b0; vga_rdn = 1'b1;
        tick();
    endtask

    task automatic test_collision();
        int rdy_at = 0, lat, wc;
        bit rdy_prev = 1'b0;
        logic [DW-1:0] exp;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0777; cpu_wdata = 16'h5555;
        ref_mem[13'h0777] = 16'h5555;
        tick();  // write now in CPU_ACC
        vga_addr = 13'h0777; vga_rdn = 1'b0;
        vga_exp_q.push_back(ref_mem[13'h0777]);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (rdy_prev) cpu_req = 1'b0;
            rdy_prev = (cpu_ready === 1'b1);
            if (rdy_prev && rdy_at == 0) rdy_at = i;
        end
        exp = vga_exp_q.pop_front();
        checks++; if (rdy_at !== 1) begin failures++; $display("FAIL col_cpu_ready got=%0d exp=1", rdy_at); end
        checks++; if (vga_data !== exp) begin failures++; $display("FAIL col_vga_bound got=%h exp=%h", vga_data, exp); end
        vga_rdn = 1'b1;
        tick();
        cpu_access(1'b0, 13'h0777, 16'h0000, lat, wc);
    endtask

    task automatic test_back_to_back();
        int base_rd = rd_cnt;
        int n_rd = 0, n_vga = 0;
        bit cpu_done = 1'b0;
`ifdef VRAM_ARB_STATS_EN
        logic [15:0] st0 = stall_cnt;
        int sm0 = stall_model;
        stat_en = 1'b1;
`endif
        fork
            begin
                int lat, wc;
                logic we;
                for (int k = 0; k < 10000; k++) begin
                    we = 1'($urandom_range(0, 1));
                    cpu_access(we, 13'($urandom_range(0, 4095)), 16'($urandom), lat, wc);
                    if (!we) n_rd++;
                end
                cpu_done = 1'b1;
            end
            begin
                logic [AW-1:0] a;
                logic [DW-1:0] exp;
                while (!cpu_done) begin
                    a = 13'($urandom_range(4096, 8191));
                    vga_addr = a;
                    vga_exp_q.push_back(ref_mem[a]);
                    vga_rdn = 1'b0;
                    repeat (4) tick();
                    vga_rdn = 1'b1;
                    tick();
                    exp = vga_exp_q.pop_front();
                    checks++;
                    if (vga_data !== exp) begin
                        failures++; $display("FAIL b2b_vga addr=%h got=%h exp=%h", a, vga_data, exp);
                    end
                    n_vga++;
                    repeat ($urandom_range(4, 10)) tick();
                end
            end
        join
        tick();
        checks++;
        if (rd_cnt - base_rd !== n_rd + n_vga) begin
            failures++; $display("FAIL b2b_fetch_count got=%0d exp=%0d", rd_cnt - base_rd, n_rd + n_vga);
        end
        checks++;
        if (cpu_exp_q.size() != 0 || vga_exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_queues_drained cpu=%0d vga=%0d exp=0", cpu_exp_q.size(), vga_exp_q.size());
        end
`ifdef VRAM_ARB_STATS_EN
        stat_en = 1'b0;
        tick();
        checks++;
        if (int'(stall_cnt - st0) !== stall_model - sm0) begin
            failures++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", stall_cnt - st0, stall_model - sm0);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = pattern(i);
            ref_mem[i] = pattern(i);
        end
        mem[13'h0123] = 16'h4E41;
        ref_mem[13'h0123] = 16'h4E41;
        test_reset();
        test_vga_alone();
        test_cpu_write_read();
        test_simultaneous();
        test_collision();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "watchdog");
    end

endmodule
